// File: rtl/song_replayer_if.sv
// Purpose: bundles the song_replayer control, RAM read port and key/status
// outputs so the engine and its surroundings connect through one port.
//   start/stop/tick  control pulses into the engine
//   song_len         number of valid entries in song memory
//   rd_addr/rd_data  synchronous RAM read port (data one cycle after address)
//   key_out          one-hot {do,re,mi} key lines, 000 = silent
//   busy/done        playback status
//   play_time        ticks elapsed since the accepted start
// master = system/RAM side, slave = playback engine.
interface song_replayer_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TIME_W = 13
);
  localparam int unsigned DATA_W = 2 + 2 * TIME_W;

  logic              start;
  logic              stop;
  logic              tick;
  logic [ADDR_W-1:0] song_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        key_out;
  logic              busy;
  logic              done;
  logic [TIME_W-1:0] play_time;

  modport master (
    output start, stop, tick, song_len, rd_data,
    input  rd_addr, key_out, busy, done, play_time
  );

  modport slave (
    input  start, stop, tick, song_len, rd_data,
    output rd_addr, key_out, busy, done, play_time
  );
endinterface

// File: rtl/song_replayer.sv
// Purpose: playback engine for recorded song memory. Walks entries
// {key[1:0], start_time, duration} from a sync RAM and drives the one-hot
// key lines at the recorded tick times for the recorded durations.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high
//   bus    song_replayer_if.slave: control pulses, RAM read port, key/status
module song_replayer #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TIME_W = 13
) (
  input  logic           clock,
  input  logic           reset,
  song_replayer_if.slave bus
);

  localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WAIT_START, S_PLAY, S_NEXT, S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0]        key;
    logic [TIME_W-1:0] start_time;
    logic [TIME_W-1:0] duration;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        key_out_q, key_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TIME_W-1:0] play_time_q, play_time_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  entry_t            entry_q, entry_d;
  entry_t            rd_entry;

  assign rd_entry = bus.rd_data;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      key_out_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      play_time_q <= '0;
      remaining_q <= '0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      key_out_q   <= key_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      play_time_q <= play_time_d;
      remaining_q <= remaining_d;
      entry_q     <= entry_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    key_out_d   = key_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    entry_d     = entry_q;
    play_time_d = play_time_q;

    // Tick counting is independent of the state, so ticks on transitions count
    if (bus.tick && busy_q && (play_time_q != TIME_MAX)) begin
      play_time_d = play_time_q + TIME_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          play_time_d = '0;
          if (bus.song_len != '0) begin
            state_d   = S_ADDR;
            rd_addr_d = '0;
            busy_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        entry_d = rd_entry;
        if ((rd_entry.key == 2'd0) || (rd_entry.duration == '0)) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        // Late entries (start already passed) fall straight through
        if (play_time_q >= entry_q.start_time) begin
          state_d     = S_PLAY;
          remaining_d = entry_q.duration;
          case (entry_q.key)
            2'd1:    key_out_d = 3'b100;
            2'd2:    key_out_d = 3'b010;
            2'd3:    key_out_d = 3'b001;
            default: key_out_d = 3'b000;
          endcase
        end
      end
      S_PLAY: begin
        if (bus.tick) begin
          if (remaining_q == TIME_W'(1)) begin
            key_out_d = '0;
            state_d   = S_NEXT;
          end else begin
            remaining_d = remaining_q - TIME_W'(1);
          end
        end
      end
      S_NEXT: begin
        if (rd_addr_q == (bus.song_len - ADDR_W'(1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          state_d   = S_ADDR;
        end
      end
      S_DONE: begin
        busy_d    = 1'b0;
        key_out_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a coincident start
    if (bus.stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      key_out_d = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.key_out   = key_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.play_time = play_time_q;

endmodule
